// File: rtl/cube_root_shared.sv
// Sequential integer cube root: floor(cbrt(in)) by MSB-first binary search,
// trial cubes formed on a single shared OUT_W x IN_W multiplier (SQ then CU).
module cube_root_shared #(
   parameter int OUT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3*OUT_W-1:0]   in,
   output logic                 busy,
   output logic                 done,
   output logic [OUT_W-1:0]     root,
   output logic [3*OUT_W-1:0]   rem
);
   localparam int IN_W  = 3 * OUT_W;
   localparam int IDX_W = $clog2(OUT_W);

   // state | meaning
   // IDLE  | waiting for start; done pulse falls here
   // SQ    | prod <= cand^2
   // CU    | prod <= cand^3
   // CMP   | keep candidate bit if cube fits, step to next bit
   // DONE  | publish root/rem, pulse done
   typedef enum logic [2:0] {S_IDLE, S_SQ, S_CU, S_CMP, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IN_W-1:0]   rad_q, rad_d;
   logic [OUT_W-1:0]  acc_q, acc_d;
   logic [IN_W-1:0]   best_rem_q, best_rem_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IN_W-1:0]   prod_q, prod_d;
   logic [OUT_W-1:0]  root_q, root_d;
   logic [IN_W-1:0]   rem_q, rem_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [OUT_W-1:0]  cand;
   logic [IN_W-1:0]   mul_a, mul_b, mul_p;

   assign cand  = acc_q | (OUT_W'(1) << idx_q);

   // The one multiplier; 255^3 fits in IN_W so truncation never loses bits.
   assign mul_a = {{(IN_W-OUT_W){1'b0}}, cand};
   assign mul_b = (state_q == S_CU) ? prod_q : mul_a;
   assign mul_p = mul_a * mul_b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rad_q      <= '0;
         acc_q      <= '0;
         best_rem_q <= '0;
         idx_q      <= '0;
         prod_q     <= '0;
         root_q     <= '0;
         rem_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rad_q      <= rad_d;
         acc_q      <= acc_d;
         best_rem_q <= best_rem_d;
         idx_q      <= idx_d;
         prod_q     <= prod_d;
         root_q     <= root_d;
         rem_q      <= rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SQ;
         S_SQ:    state_d = S_CU;
         S_CU:    state_d = S_CMP;
         S_CMP:   state_d = (idx_q == '0) ? S_DONE : S_SQ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rad_d      = rad_q;
      acc_d      = acc_q;
      best_rem_d = best_rem_q;
      idx_d      = idx_q;
      prod_d     = prod_q;
      root_d     = root_q;
      rem_d      = rem_q;
      busy_d     = busy_q;
      done_d     = done_q;
      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               rad_d      = in;
               acc_d      = '0;
               best_rem_d = in;
               idx_d      = IDX_W'(OUT_W - 1);
               busy_d     = 1'b1;
            end
         end
         S_SQ, S_CU: prod_d = mul_p;
         S_CMP: begin
            if (prod_q <= rad_q) begin
               acc_d      = cand;
               best_rem_d = rad_q - prod_q;
            end
            if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
         end
         S_DONE: begin
            root_d = acc_q;
            rem_d  = best_rem_q;
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign root = root_q;
   assign rem  = rem_q;
endmodule

// File: tb/tb_cube_root_shared.sv
// Directed and swept checks of cube_root_shared: latency, busy/done timing,
// limits, back-to-back restart, async abort, and a reference-model sweep.
module tb_cube_root_shared;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [23:0] in = '0;
   logic        busy, done;
   logic [7:0]  root;
   logic [23:0] rem;

   int n_cmp = 0;
   int n_bad = 0;

   cube_root_shared #(.OUT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in(in),
      .busy(busy), .done(done), .root(root), .rem(rem)
   );

   always #5 clk = ~clk;

   // Pulse start with value v, then wait (bounded) for done.
   task automatic run_op(input logic [23:0] v, output int lat,
                         output logic [7:0] r, output logic [23:0] m,
                         output bit timeout);
      @(negedge clk);
      start = 1'b1;
      in    = v;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      timeout = 1'b0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!done && lat < 60);
      timeout = !done;
      r = root;
      m = rem;
   endtask

   function automatic logic [7:0] ref_root(input logic [23:0] x);
      longint rr = 0;
      while ((rr + 1) * (rr + 1) * (rr + 1) <= longint'(x)) rr++;
      return 8'(rr);
   endfunction

   task automatic test_reset();
      #2;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || root !== 8'd0 || rem !== 24'd0) begin
         n_bad++;
         $display("FAIL reset: busy=%b done=%b root=%0d rem=%0d, need 0/0/0/0",
                  busy, done, root, rem);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_zero_latency();
      int  lat = 0;
      bit  busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      in    = 24'd0;
      @(posedge clk);
      #1 start = 1'b0;
      while (!done && lat < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         #1;
      end
      n_cmp++;
      if (lat !== 25) begin
         n_bad++;
         $display("FAIL zero_latency: got %0d cycles, need 25", lat);
      end
      n_cmp++;
      if (!busy_ok || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_busy: held=%b at_done=%b, need 1/0", busy_ok, busy);
      end
      n_cmp++;
      if (root !== 8'd0 || rem !== 24'd0) begin
         n_bad++;
         $display("FAIL zero_result: root=%0d rem=%0d, need 0/0", root, rem);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse: done=%b one cycle later, need 0", done);
      end
   endtask

   task automatic test_small();
      int lat; logic [7:0] r; logic [23:0] m; bit to;
      run_op(24'd27, lat, r, m, to);
      n_cmp++;
      if (to || r !== 8'd3 || m !== 24'd0) begin
         n_bad++;
         $display("FAIL cbrt27: root=%0d rem=%0d to=%b, need 3/0", r, m, to);
      end
      run_op(24'd100, lat, r, m, to);
      n_cmp++;
      if (to || r !== 8'd4 || m !== 24'd36) begin
         n_bad++;
         $display("FAIL cbrt100: root=%0d rem=%0d to=%b, need 4/36", r, m, to);
      end
   endtask

   task automatic test_limits();
      int lat; logic [7:0] r; logic [23:0] m; bit to;
      run_op(24'd16581375, lat, r, m, to);
      n_cmp++;
      if (to || r !== 8'd255 || m !== 24'd0 || lat !== 25) begin
         n_bad++;
         $display("FAIL cbrt_255cubed: root=%0d rem=%0d lat=%0d, need 255/0/25", r, m, lat);
      end
      run_op(24'hFFFFFF, lat, r, m, to);
      n_cmp++;
      if (to || r !== 8'd255 || m !== 24'd195840) begin
         n_bad++;
         $display("FAIL cbrt_max: root=%0d rem=%0d, need 255/195840", r, m);
      end
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      @(negedge clk);
      start = 1'b1;
      in    = 24'd64;
      @(posedge clk);
      #1 in = 24'd125;
      while (!done && lat < 60) begin
         @(posedge clk);
         lat++;
         #1;
      end
      n_cmp++;
      if (lat !== 25 || root !== 8'd4 || rem !== 24'd0) begin
         n_bad++;
         $display("FAIL b2b_first: root=%0d rem=%0d lat=%0d, need 4/0/25", root, rem, lat);
      end
      @(posedge clk);
      #1 start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin
         n_bad++;
         $display("FAIL b2b_accept: busy=%b after done-cycle start, need 1", busy);
      end
      lat = 1;
      while (!done && lat < 60) begin
         // stray start pulse mid-run must be ignored
         if (lat == 7) start = 1'b1;
         if (lat == 8) start = 1'b0;
         @(posedge clk);
         lat++;
         #1;
      end
      start = 1'b0;
      n_cmp++;
      if (lat !== 26 || root !== 8'd5 || rem !== 24'd0) begin
         n_bad++;
         $display("FAIL b2b_second: root=%0d rem=%0d gap=%0d, need 5/0/26", root, rem, lat);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_idle: busy=%b after pulse ignored, need 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [7:0] r; logic [23:0] m; bit to;
      bit saw_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      in    = 24'd1000;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || root !== 8'd0 || rem !== 24'd0) begin
         n_bad++;
         $display("FAIL abort: busy=%b done=%b root=%0d rem=%0d, need 0/0/0/0",
                  busy, done, root, rem);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      n_cmp++;
      if (saw_done) begin
         n_bad++;
         $display("FAIL abort_nodone: done seen=%b after abort, need 0", saw_done);
      end
      run_op(24'd1000, lat, r, m, to);
      n_cmp++;
      if (to || r !== 8'd10 || m !== 24'd0) begin
         n_bad++;
         $display("FAIL after_abort: root=%0d rem=%0d, need 10/0", r, m);
      end
   endtask

   task automatic test_sweep();
      int lat; logic [7:0] r; logic [23:0] m; bit to;
      logic [23:0] x;
      logic [7:0]  er;
      logic [23:0] em;
      int bad = 0;
      for (int i = 0; i < 2256; i++) begin
         if (i < 256) x = 24'(i * i * i);
         else x = 24'($urandom_range(24'hFFFFFF, 0));
         er = ref_root(x);
         em = x - 24'(int'(er) * int'(er) * int'(er));
         run_op(x, lat, r, m, to);
         n_cmp++;
         if (to || r !== er || m !== em) begin
            n_bad++;
            if (bad < 10)
               $display("FAIL sweep in=%0d: root=%0d rem=%0d, need %0d/%0d", x, r, m, er, em);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero_latency();
      test_small();
      test_limits();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
